// File: rtl/pipe_ctrl_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
package pipe_ctrl_pkg;

  // Controller sequencing states
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    ATOMIC = 2'd1,
    HALT   = 2'd2
  } ctrl_state_e;

  // EX operand source selects
  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_S4  = 2'd1;
  localparam logic [1:0] FWD_S5  = 2'd2;

endpackage

// File: rtl/pipe_fwd_unit.sv
// Operand forwarding compare for one EX source register.
module pipe_fwd_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned AW = 5
) (
  input  logic [AW-1:0] addr_s3,
  input  logic          rw_s4,
  input  logic [AW-1:0] waddr_s4,
  input  logic          rw_s5,
  input  logic [AW-1:0] waddr_s5,
  output logic [1:0]    sel
);

  // MEM result wins over WB; register 0 is hardwired and never forwarded
  always_comb begin
    sel = FWD_REG;
    if (!rw_s4 && (waddr_s4 != '0) && (waddr_s4 == addr_s3)) begin
      sel = FWD_S4;
    end else if (!rw_s5 && (waddr_s5 != '0) && (waddr_s5 == addr_s3)) begin
      sel = FWD_S5;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller: load-use bubbles, atomic serialisation, halt freeze,
// EX forwarding selects and a saturating stall-cycle counter.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_WORDS     = 32,
  parameter int unsigned ADDR_LEFT     = $clog2(REG_WORDS) - 1,
  parameter int unsigned ATOMIC_CYCLES = 2,
  parameter int unsigned CNT_BITS      = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_LEFT:0]  r1_addr,
  input  logic [ADDR_LEFT:0]  r2_addr,
  input  logic                r1_used,
  input  logic                r2_used,
  input  logic                sel_mem_s3,
  input  logic                rw_s3,
  input  logic [ADDR_LEFT:0]  waddr_s3,
  input  logic                atomic_s3,
  input  logic                halt_s3,
  input  logic                rw_s4,
  input  logic                rw_s5,
  input  logic [ADDR_LEFT:0]  waddr_s4,
  input  logic [ADDR_LEFT:0]  waddr_s5,
  input  logic                mem_busy,
  output logic                stall_pipe,
  output logic                hold_s1,
  output logic [1:0]          fwd_r1_sel,
  output logic [1:0]          fwd_r2_sel,
  output logic                halted,
  output logic [CNT_BITS-1:0] stall_count
);

  localparam int unsigned AW = ADDR_LEFT + 1;
  localparam int unsigned CW = (ATOMIC_CYCLES > 1) ? $clog2(ATOMIC_CYCLES) : 1;
  localparam logic [CW-1:0]       CNT_LOAD = CW'(ATOMIC_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;

  ctrl_state_e   state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [AW-1:0] r1_s3, r2_s3;
  logic          lu;
  logic [1:0]    fwd1_raw, fwd2_raw;

  // Load-use: EX load writes a register the ID instruction reads
  always_comb begin
    lu = sel_mem_s3 & ~rw_s3 & (waddr_s3 != '0) &
         ((r1_used & (r1_addr == waddr_s3)) | (r2_used & (r2_addr == waddr_s3)));
  end

  // State and atomic down-counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next state and stall/halt decode; reset forces every output low
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    stall_pipe = 1'b0;
    halted     = 1'b0;
    case (state)
      RUN: begin
        stall_pipe = lu;
        if (halt_s3) begin
          state_next = HALT;
        end else if (atomic_s3) begin
          state_next = ATOMIC;
          cnt_next   = CNT_LOAD;
        end
      end
      ATOMIC: begin
        stall_pipe = 1'b1;
        if (cnt != '0) begin
          cnt_next = cnt - CW'(1);
        end else if (!mem_busy) begin
          state_next = RUN;
        end
      end
      HALT: begin
        stall_pipe = 1'b1;
        halted     = 1'b1;
      end
      default: state_next = RUN;
    endcase
    if (rst) begin
      stall_pipe = 1'b0;
      halted     = 1'b0;
    end
    hold_s1 = stall_pipe;
  end

  // Shadow of the ID/EX source addresses (bubble clears them) and stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r1_s3       <= '0;
      r2_s3       <= '0;
      stall_count <= '0;
    end else begin
      if (stall_pipe) begin
        r1_s3 <= '0;
        r2_s3 <= '0;
      end else begin
        r1_s3 <= r1_addr;
        r2_s3 <= r2_addr;
      end
      if (stall_pipe && (stall_count != CNT_MAX)) begin
        stall_count <= stall_count + CNT_BITS'(1);
      end
    end
  end

  pipe_fwd_unit #(.AW(AW)) u_fwd_r1 (
    .addr_s3  (r1_s3),
    .rw_s4    (rw_s4),
    .waddr_s4 (waddr_s4),
    .rw_s5    (rw_s5),
    .waddr_s5 (waddr_s5),
    .sel      (fwd1_raw)
  );

  pipe_fwd_unit #(.AW(AW)) u_fwd_r2 (
    .addr_s3  (r2_s3),
    .rw_s4    (rw_s4),
    .waddr_s4 (waddr_s4),
    .rw_s5    (rw_s5),
    .waddr_s5 (waddr_s5),
    .sel      (fwd2_raw)
  );

  // Forwarding selects are held at the regfile source while in reset
  always_comb begin
    fwd_r1_sel = rst ? FWD_REG : fwd1_raw;
    fwd_r2_sel = rst ? FWD_REG : fwd2_raw;
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomised and directed check of pipe_hazard_ctrl against a behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int AC   = 2;
  localparam int CB   = 4;
  localparam int CMAX = (1 << CB) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    r1_addr, r2_addr, waddr_s3, waddr_s4, waddr_s5;
  logic          r1_used, r2_used, sel_mem_s3, rw_s3, atomic_s3, halt_s3;
  logic          rw_s4, rw_s5, mem_busy;
  logic          stall_pipe, hold_s1, halted;
  logic [1:0]    fwd_r1_sel, fwd_r2_sel;
  logic [CB-1:0] stall_count;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: mode 0=run 1=atomic 2=halt, age = atomic cycles spent
  int m_mode = 0;
  int m_age  = 0;
  int m_cnt  = 0;
  int m_a1   = 0;
  int m_a2   = 0;

  pipe_hazard_ctrl #(
    .REG_WORDS(32), .ATOMIC_CYCLES(AC), .CNT_BITS(CB)
  ) dut (
    .clk(clk), .rst(rst),
    .r1_addr(r1_addr), .r2_addr(r2_addr), .r1_used(r1_used), .r2_used(r2_used),
    .sel_mem_s3(sel_mem_s3), .rw_s3(rw_s3), .waddr_s3(waddr_s3),
    .atomic_s3(atomic_s3), .halt_s3(halt_s3),
    .rw_s4(rw_s4), .rw_s5(rw_s5), .waddr_s4(waddr_s4), .waddr_s5(waddr_s5),
    .mem_busy(mem_busy),
    .stall_pipe(stall_pipe), .hold_s1(hold_s1),
    .fwd_r1_sel(fwd_r1_sel), .fwd_r2_sel(fwd_r2_sel),
    .halted(halted), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_lu();
    if (sel_mem_s3 && !rw_s3 && waddr_s3 != 0 &&
        ((r1_used && r1_addr == waddr_s3) || (r2_used && r2_addr == waddr_s3)))
      return 1;
    return 0;
  endfunction

  function automatic int exp_fwd(input int a);
    if (rst) return 0;
    if (!rw_s4 && waddr_s4 != 0 && int'(waddr_s4) == a) return 1;
    if (!rw_s5 && waddr_s5 != 0 && int'(waddr_s5) == a) return 2;
    return 0;
  endfunction

  function automatic int exp_stall();
    if (rst) return 0;
    if (m_mode != 0) return 1;
    return exp_lu();
  endfunction

  task automatic idle_inputs();
    rst = 1'b0; r1_addr = '0; r2_addr = '0; r1_used = 1'b0; r2_used = 1'b0;
    sel_mem_s3 = 1'b0; rw_s3 = 1'b1; waddr_s3 = '0; atomic_s3 = 1'b0; halt_s3 = 1'b0;
    rw_s4 = 1'b1; rw_s5 = 1'b1; waddr_s4 = '0; waddr_s5 = '0; mem_busy = 1'b0;
  endtask

  // One clock: check outputs mid-cycle, then advance the model at the edge
  task automatic cycle();
    int st;
    @(negedge clk);
    #1;
    st = exp_stall();
    check("stall_pipe", 32'(stall_pipe), 32'(st));
    check("hold_s1", 32'(hold_s1), 32'(st));
    check("halted", 32'(halted), 32'((!rst && m_mode == 2) ? 1 : 0));
    check("fwd_r1_sel", 32'(fwd_r1_sel), 32'(exp_fwd(m_a1)));
    check("fwd_r2_sel", 32'(fwd_r2_sel), 32'(exp_fwd(m_a2)));
    check("stall_count", 32'(stall_count), 32'(m_cnt));
    @(posedge clk);
    if (rst) begin
      m_mode = 0; m_age = 0; m_cnt = 0; m_a1 = 0; m_a2 = 0;
    end else begin
      if (st != 0 && m_cnt < CMAX) m_cnt++;
      m_a1 = (st != 0) ? 0 : int'(r1_addr);
      m_a2 = (st != 0) ? 0 : int'(r2_addr);
      if (m_mode == 0) begin
        if (halt_s3) m_mode = 2;
        else if (atomic_s3) begin m_mode = 1; m_age = 0; end
      end else if (m_mode == 1) begin
        if (m_age + 1 >= AC && !mem_busy) m_mode = 0;
        else m_age++;
      end
    end
    #1;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (2) cycle();
    rst = 1'b0;
    cycle();

    // Load-use on r1 then a bubble
    sel_mem_s3 = 1'b1; rw_s3 = 1'b0; waddr_s3 = 5'd5; r1_addr = 5'd5; r1_used = 1'b1;
    cycle();
    idle_inputs();
    cycle();
    check("lu_count", 32'(stall_count), 32'd1);
    // Load to r0 never stalls
    sel_mem_s3 = 1'b1; rw_s3 = 1'b0; waddr_s3 = 5'd0; r1_addr = 5'd0; r1_used = 1'b1;
    cycle();
    idle_inputs();

    // Atomic with idle memory, then with memory busy for the first four stall cycles
    atomic_s3 = 1'b1; cycle(); atomic_s3 = 1'b0;
    repeat (4) cycle();
    atomic_s3 = 1'b1; cycle(); atomic_s3 = 1'b0;
    mem_busy = 1'b1; repeat (4) cycle();
    mem_busy = 1'b0; repeat (3) cycle();

    // Forwarding priority on r2
    r2_addr = 5'd7; cycle();
    rw_s4 = 1'b0; waddr_s4 = 5'd7; rw_s5 = 1'b0; waddr_s5 = 5'd7;
    #1 check("fwd_s4_prio", 32'(fwd_r2_sel), 32'd1);
    cycle();
    rw_s4 = 1'b1;
    #1 check("fwd_s5", 32'(fwd_r2_sel), 32'd2);
    r2_addr = 5'd0; cycle();
    check("fwd_r0", 32'(fwd_r2_sel), 32'd0);
    idle_inputs();

    // Reset in the first atomic stall cycle
    atomic_s3 = 1'b1; cycle(); atomic_s3 = 1'b0;
    rst = 1'b1; cycle(); rst = 1'b0;
    cycle();
    check("rst_atomic_stall", 32'(stall_pipe), 32'd0);
    check("rst_atomic_cnt", 32'(stall_count), 32'd0);

    // Halt freeze for 20 cycles saturates the 4-bit counter
    halt_s3 = 1'b1; cycle(); halt_s3 = 1'b0;
    repeat (20) cycle();
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_sat", 32'(stall_count), 32'(CMAX));
    rst = 1'b1; cycle(); rst = 1'b0; cycle();

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 59) == 0);
      r1_addr    = 5'($urandom_range(0, 7));
      r2_addr    = 5'($urandom_range(0, 7));
      r1_used    = 1'($urandom_range(0, 1));
      r2_used    = 1'($urandom_range(0, 1));
      sel_mem_s3 = ($urandom_range(0, 2) == 0);
      rw_s3      = ($urandom_range(0, 3) == 0);
      waddr_s3   = 5'($urandom_range(0, 7));
      atomic_s3  = ($urandom_range(0, 9) == 0);
      halt_s3    = ($urandom_range(0, 149) == 0);
      rw_s4      = 1'($urandom_range(0, 1));
      rw_s5      = 1'($urandom_range(0, 1));
      waddr_s4   = 5'($urandom_range(0, 7));
      waddr_s5   = 5'($urandom_range(0, 7));
      mem_busy   = ($urandom_range(0, 2) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and stall controller for the 5-stage pipeline; it sequences the ID/EX pipeline register and the IF/ID hold. It detects load-use hazards, serialises atomic operations, freezes on halt, and produces operand-forwarding selects for EX. It sits beside the ID/EX register. It drives that register's `stall_pipe` (bubble insert) and the IF/ID/PC `hold_s1`, and keeps a saturating stall-cycle counter for performance debug.

## Interface
Clock `clk`; reset `rst` is synchronous and active-high (single clock domain).

Parameters:
- REG_WORDS, 32, regfile depth
- ADDR_LEFT, $clog2(REG_WORDS)-1, regfile address MSB
- ATOMIC_CYCLES, 2, minimum stall cycles after an atomic reaches EX (≥1)
- CNT_BITS, 16, stall counter width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- r1_addr, r2_addr  in  ADDR_LEFT+1  source registers of the instruction in ID
- r1_used, r2_used  in  1  the ID instruction actually reads r1/r2
- sel_mem_s3  in  1  EX instruction is a load
- rw_s3  in  1  EX instruction regfile write enable, active-low
- waddr_s3  in  ADDR_LEFT+1  EX destination register
- atomic_s3  in  1  EX instruction is atomic (LL/SC)
- halt_s3  in  1  EX instruction is halt
- rw_s4, rw_s5  in  1  MEM/WB write enables, active-low
- waddr_s4, waddr_s5  in  ADDR_LEFT+1  MEM/WB destinations
- mem_busy  in  1  data memory has not yet completed an access
- stall_pipe  out  1  insert a bubble into ID/EX on the next edge
- hold_s1  out  1  freeze PC and IF/ID on the next edge
- fwd_r1_sel, fwd_r2_sel  out  2  EX operand source: 0 = regfile/ID-EX data, 1 = MEM-stage result, 2 = WB result
- halted  out  1  pipeline frozen by halt
- stall_count  out  CNT_BITS  saturating count of cycles with stall_pipe=1

## Operation
- States: RUN, ATOMIC, HALT.
- Load-use (combinational, RUN only):
  - `lu = sel_mem_s3 & ~rw_s3 & waddr_s3!=0 & ((r1_used & r1_addr==waddr_s3) | (r2_used & r2_addr==waddr_s3))`.
  - lu drives stall_pipe=1 and hold_s1=1 for exactly the current cycle.
  - The bubble leaves s3 on the next cycle, so lu clears on its own.
- RUN → HALT when halt_s3=1. Priority is HALT > ATOMIC > lu.
- RUN → ATOMIC when atomic_s3=1. On entry, load cnt=ATOMIC_CYCLES-1.
- ATOMIC:
  - stall_pipe=1 and hold_s1=1.
  - cnt decrements each cycle (never below 0).
  - Exit to RUN in the cycle when cnt==0 and mem_busy=0. mem_busy extends the stay indefinitely.
  - halt_s3=1 while in ATOMIC is ignored, because s3 holds a bubble.
- HALT:
  - hold_s1=1, stall_pipe=1, halted=1.
  - Left only by rst.
- Forwarding (combinational, independent of state), per operand n:
  - fwd_rn_sel=1 if ~rw_s4 & waddr_s4!=0 & waddr_s4==rn_addr_s3.
  - Otherwise 2 if the same condition holds for s5.
  - Otherwise 0.
  - The s4 match has priority over s5. Register 0 is never forwarded.
  - rn_addr_s3 is captured internally: on each edge, r1_addr/r2_addr are registered when stall_pipe=0, and cleared to 0 when stall_pipe=1. This mirrors the ID/EX behaviour.
- stall_count increments on every edge where stall_pipe=1 and saturates at all-ones.

## Timing
- While rst=1, all outputs are forced to 0. On the first edge with rst=1:
  - state=RUN, cnt=0, stall_count=0;
  - captured s3 addresses=0;
  - halted=0, stall_pipe=0, hold_s1=0, fwd selects=0.
- Reset during ATOMIC or HALT returns to RUN on that edge, with no residual stall.
- Load-use adds exactly 1 cycle of latency.
- Atomic costs max(ATOMIC_CYCLES, cycles until mem_busy falls) stall cycles. With ATOMIC_CYCLES=1 and mem_busy=0, the cost is 1 cycle.
- State outputs are decoded from registered state. Only lu and the forwarding selects are combinational from inputs.
- If lu and atomic_s3 are both asserted in RUN: stall this cycle, then enter ATOMIC. There is no double count in the same cycle; stall_count increments once per cycle.

## Structure
- Package pipe_ctrl_pkg holds:
  - the state enum typedef (RUN/ATOMIC/HALT);
  - the FWD_REG/FWD_S4/FWD_S5 2-bit encodings.
- Sub-module pipe_fwd_unit holds the combinational forwarding compare. It is instantiated once per operand.

## Test plan
- Load-use stall:
  - Stimulus: sel_mem_s3=1, rw_s3=0, waddr_s3=5; ID r1_addr=5, r1_used=1.
  - Response: stall_pipe=hold_s1=1 for one cycle; stall_count=1.
  - Repeat with waddr_s3=0: no stall.
- Atomic sequencing:
  - Stimulus: atomic_s3=1 with ATOMIC_CYCLES=2, mem_busy=0.
  - Response: 1 cycle in RUN with no stall, then 2 stall cycles, then RUN.
  - Repeat with mem_busy held for 5 cycles: the stall lasts 5 cycles.
- Forwarding priority:
  - Stimulus: s3 r2=7; rw_s4=0, waddr_s4=7; rw_s5=0, waddr_s5=7.
  - Response: fwd_r2_sel=1.
  - With rw_s4=1: fwd_r2_sel=2. With r2=0: fwd_r2_sel=0.
- Halt:
  - Stimulus: halt_s3=1.
  - Response: next cycle halted=1, stall_pipe=hold_s1=1, held for 20 cycles; stall_count=20.
- Reset mid-operation:
  - Stimulus: rst=1 during ATOMIC with cnt=1, then release.
  - Response: all outputs 0, state RUN, stall_count=0.
- Saturation:
  - Setup: CNT_BITS=4, stall for 20 cycles.
  - Response: stall_count holds at 15.
